// File: rtl/circuit_boolean_ca_pkg.sv
// circuit_boolean_ca_pkg: the two per-lane Boolean functions and minterm count shared by the evaluator.
package circuit_boolean_ca_pkg;
   localparam int NUM_MINTERMS = 16;
   function automatic logic f_e(input logic a, input logic b, input logic c, input logic d);
      return a | (b & c) | (~b & d);
   endfunction
   function automatic logic f_f(input logic a, input logic b, input logic c, input logic d);
      return (~b & c) | (b & ~c & d) | (a & 1'b0);
   endfunction
endpackage

// File: rtl/circuit_boolean_ca_lane.sv
// circuit_boolean_ca_lane: combinational single-lane evaluator of E and F.
module circuit_boolean_ca_lane
   import circuit_boolean_ca_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic e,
   output logic f
);
   assign e = f_e(a, b, c, d);
   assign f = f_f(a, b, c, d);
endmodule

// File: rtl/circuit_boolean_ca.sv
// circuit_boolean_ca: registered LANES-wide E/F evaluator with one-cycle latency.
// Define CIRCUIT_BOOLEAN_CA_STATS_EN to build saturating lane-0 minterm hit counters.
module circuit_boolean_ca
   import circuit_boolean_ca_pkg::*;
#(
   parameter int LANES   = 1,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [LANES-1:0]   A,
   input  logic [LANES-1:0]   B,
   input  logic [LANES-1:0]   C,
   input  logic [LANES-1:0]   D,
   output logic               out_valid,
   output logic [LANES-1:0]   E,
   output logic [LANES-1:0]   F,
   input  logic [3:0]         stat_sel,
   output logic [COUNT_W-1:0] stat_cnt
);
   logic [LANES-1:0] e_c, f_c;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      circuit_boolean_ca_lane u_lane (
         .a(A[i]), .b(B[i]), .c(C[i]), .d(D[i]), .e(e_c[i]), .f(f_c[i])
      );
   end
   // E/F only load on valid so idle or unknown operands never disturb the held result
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         E         <= '0;
         F         <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            E <= e_c;
            F <= f_c;
         end
      end
   end
`ifdef CIRCUIT_BOOLEAN_CA_STATS_EN
   logic [COUNT_W-1:0] cnt [NUM_MINTERMS];
   logic [3:0]         idx;
   assign idx = {A[0], B[0], C[0], D[0]};
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_MINTERMS; k++) cnt[k] <= '0;
      end else if (in_valid && cnt[idx] != '1) begin
         cnt[idx] <= cnt[idx] + COUNT_W'(1);
      end
   end
   assign stat_cnt = cnt[stat_sel];
`else
   logic unused_stat_sel;
   assign unused_stat_sel = ^stat_sel;
   assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_circuit_boolean_ca.sv
// tb_circuit_boolean_ca: truth-table model bench for circuit_boolean_ca (4 lanes, 2-bit counters).
module tb_circuit_boolean_ca;
   localparam int L  = 4;
   localparam int CW = 2;
   logic          clk = 1'b0;
   logic          rst, in_valid;
   logic [L-1:0]  A, B, C, D;
   logic [3:0]    stat_sel;
   logic          out_valid;
   logic [L-1:0]  E, F;
   logic [CW-1:0] stat_cnt;
   int checks = 0, failures = 0;
   logic [15:0] e_tt = 16'hFFCA;
   logic [15:0] f_tt = 16'h2C2C;
   logic         m_v = 1'b0;
   logic [L-1:0] m_e = '0, m_f = '0;
   int           m_hits [16];
   logic [3:0]   seq [5]  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF};
   logic         seq_e [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic         seq_f [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   circuit_boolean_ca #(.LANES(L), .COUNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .A(A), .B(B), .C(C), .D(D),
      .out_valid(out_valid), .E(E), .F(F),
      .stat_sel(stat_sel), .stat_cnt(stat_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [L-1:0] a, input logic [L-1:0] b,
                        input logic [L-1:0] c, input logic [L-1:0] d);
      rst = r; in_valid = v; A = a; B = b; C = c; D = d;
   endtask

   task automatic vec(input logic [3:0] abcd);
      drive(1'b0, 1'b1, {L{abcd[3]}}, {L{abcd[2]}}, {L{abcd[1]}}, {L{abcd[0]}});
   endtask

   function automatic int exp_stat(input logic [3:0] sel);
`ifdef CIRCUIT_BOOLEAN_CA_STATS_EN
      return m_hits[sel] > 3 ? 3 : m_hits[sel];
`else
      return 0;
`endif
   endfunction

   // Advance one edge, update the model from the operands just sampled, then compare at the falling edge
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_v = 1'b0; m_e = '0; m_f = '0;
         foreach (m_hits[k]) m_hits[k] = 0;
      end else begin
         m_v = in_valid;
         if (in_valid) begin
            for (int i = 0; i < L; i++) begin
               m_e[i] = e_tt[{A[i], B[i], C[i], D[i]}];
               m_f[i] = f_tt[{A[i], B[i], C[i], D[i]}];
            end
            m_hits[{A[0], B[0], C[0], D[0]}]++;
         end
      end
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(m_v));
      chk("E", 64'(E), 64'(m_e));
      chk("F", 64'(F), 64'(m_f));
      chk("stat_cnt", 64'(stat_cnt), 64'(exp_stat(stat_sel)));
   endtask

   initial begin
      foreach (m_hits[k]) m_hits[k] = 0;
      stat_sel = 4'd0;
      drive(1'b1, 1'b1, '1, '1, '1, '1);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("reset_valid", 64'(out_valid), 64'd0);
         chk("reset_E", 64'(E), 64'd0);
         chk("reset_F", 64'(F), 64'd0);
      end
      for (int k = 0; k < 5; k++) begin
         vec(seq[k]);
         tick();
         chk("seq_valid", 64'(out_valid), 64'd1);
         chk("seq_E", 64'(E), 64'({L{seq_e[k]}}));
         chk("seq_F", 64'(F), 64'({L{seq_f[k]}}));
      end
      for (int c = 0; c < 16; c++) begin
         vec(4'(c));
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, L'($urandom), L'($urandom), L'($urandom), L'($urandom));
         tick();
         chk("idle_valid", 64'(out_valid), 64'd0);
         chk("idle_E", 64'(E), 64'hF);
         chk("idle_F", 64'(F), 64'h0);
      end
      drive(1'b0, 1'b1, 4'b0000, 4'b0101, 4'b0110, 4'b1011);
      tick();
      chk("lanes_E", 64'(E), 64'b1110);
      chk("lanes_F", 64'(F), 64'b0011);
      drive(1'b1, 1'b0, '0, '0, '0, '0);
      tick();
      stat_sel = 4'd5;
      for (int k = 0; k < 5; k++) begin
         vec(4'b0101);
         tick();
      end
      drive(1'b0, 1'b0, '0, '0, '0, '0);
      #1;
`ifdef CIRCUIT_BOOLEAN_CA_STATS_EN
      chk("stat_sat", 64'(stat_cnt), 64'd3);
      stat_sel = 4'd0;
      #1;
      chk("stat_zero", 64'(stat_cnt), 64'd0);
      stat_sel = 4'd5;
`else
      chk("stat_tied", 64'(stat_cnt), 64'd0);
`endif
      drive(1'b1, 1'b0, '0, '0, '0, '0);
      tick();
      chk("stat_clear", 64'(stat_cnt), 64'd0);
      vec(4'b0011);
      tick();
      chk("mid_E", 64'(E), 64'hF);
      chk("mid_F", 64'(F), 64'hF);
      drive(1'b1, 1'b1, '1, '1, '1, '1);
      tick();
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_E", 64'(E), 64'd0);
      chk("mid_rst_F", 64'(F), 64'd0);
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
               L'($urandom), L'($urandom), L'($urandom), L'($urandom));
         stat_sel = 4'($urandom);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
